// File: rtl/uart_msg_sequencer.sv
// uart_msg_sequencer
//   Streams a compile-time message, one byte at a time, into a txuart-style
//   stb/busy byte interface. A message is started one-shot by i_trigger, or
//   periodically every REPEAT_PERIOD_CLKS clocks while i_periodic is high.
//   Start requests that arrive while a message is in flight collapse into a
//   single pending request, which is served after the current message ends.
//
// Ports
//   i_clk        clock, all logic on posedge
//   i_reset_n    synchronous active-low reset
//   i_enable     0 blocks new messages; a message in progress still completes
//   i_periodic   1 runs the period counter; 0 holds it at its reload value
//   i_trigger    start request, sampled every cycle
//   o_tx_stb     byte valid towards txuart
//   o_tx_data    byte being offered; 0 while idle
//   i_tx_busy    txuart busy; a byte is taken when o_tx_stb && !i_tx_busy
//   o_busy       high while a message is being sent
//   o_done       one-cycle pulse after the last byte is taken
//   o_msg_count  number of completed messages, wraps at 16 bits
module uart_msg_sequencer #(
    parameter int unsigned          MSG_LEN            = 16,
    parameter logic [8*MSG_LEN-1:0] MSG                = "Hello, World! \n\r",
    parameter int unsigned          REPEAT_PERIOD_CLKS = 100_000_000,
    parameter int unsigned          IDX_W              = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_enable,
    input  logic        i_periodic,
    input  logic        i_trigger,
    output logic        o_tx_stb,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_busy,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_msg_count
);

    localparam int unsigned SEL_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [31:0] RELOAD = 32'(REPEAT_PERIOD_CLKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             pending, pending_n;
    logic             done_q, done_n;
    logic [15:0]      count_q, count_n;
    logic [31:0]      per_cnt;
    logic             per_expire;
    logic             start;

    // Byte 0 is the most significant byte of MSG.
    logic [7:0] msg_bytes [MSG_LEN];
    for (genvar g = 0; g < MSG_LEN; g++) begin : g_bytes
        assign msg_bytes[g] = MSG[8*(MSG_LEN-g)-1 -: 8];
    end

    assign per_expire = i_periodic && (per_cnt == '0);
    assign start      = i_trigger || per_expire;

    // Period counter runs independently of the FSM state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            per_cnt <= RELOAD;
        end else if (!i_periodic || per_cnt == '0) begin
            per_cnt <= RELOAD;
        end else begin
            per_cnt <= per_cnt - 32'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            pending <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            pending <= pending_n;
            done_q  <= done_n;
            count_q <= count_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        pending_n = pending || start;
        done_n    = 1'b0;
        count_n   = count_q;
        case (state)
            IDLE: begin
                // The start seen in this cycle is consumed together with any
                // older pending request.
                if (i_enable && pending_n) begin
                    state_n   = SEND;
                    idx_n     = '0;
                    pending_n = 1'b0;
                end
            end
            SEND: begin
                if (!i_tx_busy) begin
                    if (idx == LAST_IDX) begin
                        state_n = IDLE;
                        idx_n   = '0;
                        done_n  = 1'b1;
                        count_n = count_q + 16'd1;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_tx_stb    = (state == SEND);
    assign o_busy      = (state == SEND);
    assign o_tx_data   = (state == SEND) ? msg_bytes[idx[SEL_W-1:0]] : 8'h00;
    assign o_done      = done_q;
    assign o_msg_count = count_q;

endmodule
